// File: rtl/regfile_gazump_mux_pkg.sv
// -----------------------------------------------------------------------------
// regfile_gazump_mux_pkg
//
// Purpose
//   Shared constants, types and helper functions for the gazump operand mux.
//   The port counts are fixed by the gazump match generator and must not be
//   changed independently of it.
//
// Contents
//   GZ_NRD       number of regfile read ports (operands per bundle)
//   GZ_NWR       number of write ports that can gazump a read
//   GZ_MW        match vector width per read port (one bit per write port
//                plus the "no gazump" bit)
//   GZ_NONE_BIT  index of the "no gazump, use regfile data" bit
//   GZ_CW        width of a popcount over one match vector or the port vector
//   gz_match_t   one read port's match vector
//   gz_port_t    one bit per read port
// -----------------------------------------------------------------------------
package regfile_gazump_mux_pkg;

    localparam int GZ_NRD      = 9;
    localparam int GZ_NWR      = 10;
    localparam int GZ_MW       = GZ_NWR + 1;
    localparam int GZ_NONE_BIT = GZ_NWR;

    // 4 bits cover both 0..11 (one match vector) and 0..9 (one bit per port).
    localparam int GZ_CW       = 4;

    typedef logic [GZ_MW-1:0]  gz_match_t;
    typedef logic [GZ_NRD-1:0] gz_port_t;

    // Number of set bits in one read port's match vector.
    function automatic logic [GZ_CW-1:0] gz_match_popcount(input gz_match_t v);
        logic [GZ_CW-1:0] n;
        n = '0;
        for (int i = 0; i < GZ_MW; i++) begin
            n = n + {{(GZ_CW-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Number of read ports whose operand came from a write port.
    function automatic logic [GZ_CW-1:0] gz_port_popcount(input gz_port_t v);
        logic [GZ_CW-1:0] n;
        n = '0;
        for (int i = 0; i < GZ_NRD; i++) begin
            n = n + {{(GZ_CW-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage : regfile_gazump_mux_pkg

// File: rtl/regfile_gazump_mux_if.sv
// -----------------------------------------------------------------------------
// regfile_gazump_mux_if
//
// Purpose
//   Bundles the match/data input handshake and the operand output handshake
//   of regfile_gazump_mux. Clock and reset are not part of the bundle.
//
// Parameters
//   DATA_WIDTH  operand width
//   CNT_W       gazump-hit counter width
//
// Signals (direction as seen from the mux, i.e. the slave modport)
//   in_valid    in   match/data valid (read clock enable delayed one cycle)
//   in_ready    out  stage can accept this cycle
//   match       in   GZ_NRD match vectors, port k at [k*GZ_MW +: GZ_MW]
//   rf_data     in   regfile read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   wdata       in   write-port data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid   out  operand bundle valid
//   out_ready   in   downstream accepts the bundle
//   out_data    out  selected operands, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_gz      out  per read port: operand came from a write port
//   err_onehot  out  sticky: some accepted match vector was not one-hot
//   gz_count    out  saturating count of port-level gazump hits
//
// Modports
//   master  the upstream/downstream environment (drives inputs)
//   slave   the mux itself
// -----------------------------------------------------------------------------
interface regfile_gazump_mux_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 16
);
    import regfile_gazump_mux_pkg::*;

    logic                           in_valid;
    logic                           in_ready;
    logic [GZ_NRD*GZ_MW-1:0]        match;
    logic [GZ_NRD*DATA_WIDTH-1:0]   rf_data;
    logic [GZ_NWR*DATA_WIDTH-1:0]   wdata;

    logic                           out_valid;
    logic                           out_ready;
    logic [GZ_NRD*DATA_WIDTH-1:0]   out_data;
    logic [GZ_NRD-1:0]              out_gz;

    logic                           err_onehot;
    logic [CNT_W-1:0]               gz_count;

    modport master (
        output in_valid, match, rf_data, wdata, out_ready,
        input  in_ready, out_valid, out_data, out_gz, err_onehot, gz_count
    );

    modport slave (
        input  in_valid, match, rf_data, wdata, out_ready,
        output in_ready, out_valid, out_data, out_gz, err_onehot, gz_count
    );

endinterface : regfile_gazump_mux_if

// File: rtl/regfile_gazump_mux0.sv
// -----------------------------------------------------------------------------
// regfile_gazump_mux0
//
// Purpose
//   Operand select for a single read port. Purely combinational.
//   The match vector is expected to be one-hot: bit GZ_NONE_BIT picks the
//   regfile read data, bit i picks write port i's data. The select is an
//   AND-OR over all GZ_MW terms, so a multi-hot vector returns the OR of the
//   selected buses and an all-zero vector returns zero. Unselected buses are
//   masked with a known 0, so X on them never reaches the output.
//
// Ports
//   match_i        in   one read port's match vector
//   rf_data_i      in   regfile read data for this port
//   wdata_i        in   all write-port data buses, port i at [i*DW +: DW]
//   data_o         out  selected operand
//   gz_o           out  operand came from a write port (no-gazump bit clear)
//   onehot_err_o   out  match vector does not have exactly one bit set
// -----------------------------------------------------------------------------
module regfile_gazump_mux0
    import regfile_gazump_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  gz_match_t                     match_i,
    input  logic [DATA_WIDTH-1:0]         rf_data_i,
    input  logic [GZ_NWR*DATA_WIDTH-1:0]  wdata_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          gz_o,
    output logic                          onehot_err_o
);

    always_comb begin
        // NOTE: data_o gets a full value before the loop so every path assigns
        // it; leaving it unassigned on some path would infer a latch.
        data_o = {DATA_WIDTH{match_i[GZ_NONE_BIT]}} & rf_data_i;
        for (int i = 0; i < GZ_NWR; i++) begin
            data_o = data_o
                   | ({DATA_WIDTH{match_i[i]}} & wdata_i[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // A port counts as gazumped whenever it is not explicitly told to use the
    // regfile, which includes the illegal all-zero vector.
    assign gz_o = ~match_i[GZ_NONE_BIT];

    // Zero bits and more than one bit are both violations.
    assign onehot_err_o = (gz_match_popcount(match_i) != 4'd1);

endmodule : regfile_gazump_mux0

// File: rtl/regfile_gazump_mux.sv
// -----------------------------------------------------------------------------
// regfile_gazump_mux
//
// Purpose
//   Consumes the gazump match vectors for all read ports, selects each
//   operand from the regfile read data or from one of the write-port buses,
//   and registers the operand bundle in a single valid/ready stage that feeds
//   the ALU operand latches. Also tracks a sticky one-hot violation flag and
//   a saturating count of port-level gazump hits.
//
// Parameters
//   DATA_WIDTH  operand width (must match the interface instance)
//   CNT_W       gazump-hit counter width (must match the interface instance)
//
// Ports
//   clk   in   clock
//   rst   in   synchronous reset, active high
//   bus   slave modport of regfile_gazump_mux_if (handshakes, data, status)
//
// Behaviour summary
//   in_ready = ~out_valid | out_ready, purely combinational (no skid buffer).
//   A beat is accepted when in_valid & in_ready; its operands appear on the
//   outputs one cycle later with out_valid set. With out_ready held high the
//   stage sustains one bundle per cycle. When the downstream drains the
//   bundle without a new accept, out_valid drops but the data is kept.
// -----------------------------------------------------------------------------
module regfile_gazump_mux
    import regfile_gazump_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_gazump_mux_if.slave   bus
);

    localparam int RD_W  = GZ_NRD * DATA_WIDTH;
    // Wide enough to hold the counter plus one cycle's worth of hits.
    localparam int SUM_W = CNT_W + GZ_CW;
    localparam logic [SUM_W-1:0] CNT_MAX = {{GZ_CW{1'b0}}, {CNT_W{1'b1}}};

    // ------------------------------------------------------------------
    // Per-port operand select
    // ------------------------------------------------------------------
    logic [RD_W-1:0]   mux_data;
    gz_port_t          mux_gz;
    gz_port_t          port_err;

    for (genvar k = 0; k < GZ_NRD; k++) begin : g_port
        regfile_gazump_mux0 #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_sel (
            .match_i      (bus.match[k*GZ_MW +: GZ_MW]),
            .rf_data_i    (bus.rf_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .wdata_i      (bus.wdata),
            .data_o       (mux_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .gz_o         (mux_gz[k]),
            .onehot_err_o (port_err[k])
        );
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic out_valid_q, out_valid_d;
    logic accept;

    // A beat offered while in_ready is low is simply not accepted.
    assign bus.in_ready = ~out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

    // ------------------------------------------------------------------
    // Saturating hit counter arithmetic
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  gz_count_q, gz_count_d;
    logic [SUM_W-1:0]  cnt_sum;
    logic [CNT_W-1:0]  cnt_sat;

    // Counts the gz bits being loaded this cycle, i.e. the next out_gz.
    assign cnt_sum = {{GZ_CW{1'b0}}, gz_count_q}
                   + {{CNT_W{1'b0}}, gz_port_popcount(mux_gz)};
    assign cnt_sat = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [RD_W-1:0]   out_data_q, out_data_d;
    gz_port_t          out_gz_q, out_gz_d;
    logic              err_onehot_q, err_onehot_d;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_gz_d     = out_gz_q;
        err_onehot_d = err_onehot_q;
        gz_count_d   = gz_count_q;

        if (accept) begin
            // Also covers accept together with out_ready: the new bundle
            // replaces the one being drained and out_valid stays high.
            out_valid_d  = 1'b1;
            out_data_d   = mux_data;
            out_gz_d     = mux_gz;
            err_onehot_d = err_onehot_q | (|port_err);
            gz_count_d   = cnt_sat;
        end else if (bus.out_ready) begin
            // Bundle consumed with nothing behind it; data is left in place.
            out_valid_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: the data and gz registers are reset too, not just out_valid,
    // because their reset value of zero is visible on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_gz_q     <= '0;
            err_onehot_q <= 1'b0;
            gz_count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_gz_q     <= out_gz_d;
            err_onehot_q <= err_onehot_d;
            gz_count_q   <= gz_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_gz     = out_gz_q;
    assign bus.err_onehot = err_onehot_q;
    assign bus.gz_count   = gz_count_q;

endmodule : regfile_gazump_mux

// File: tb/tb_regfile_gazump_mux.sv
// -----------------------------------------------------------------------------
// tb_regfile_gazump_mux
//
// Self-checking bench for regfile_gazump_mux. Two instances are used: one with
// the default 16-bit hit counter for the datapath/handshake tests and one with
// a 4-bit counter for the saturation test. Expected bundles are pushed to a
// scoreboard when a beat is driven and popped when the DUT presents it.
// -----------------------------------------------------------------------------
module tb_regfile_gazump_mux;
    import regfile_gazump_mux_pkg::*;

    localparam int DW  = 32;
    localparam int MVW = GZ_NRD * GZ_MW;
    localparam int RDW = GZ_NRD * DW;
    localparam int WDW = GZ_NWR * DW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_gazump_mux_if #(.DATA_WIDTH(DW), .CNT_W(16)) ifa ();
    regfile_gazump_mux_if #(.DATA_WIDTH(DW), .CNT_W(4))  ifb ();

    regfile_gazump_mux #(.DATA_WIDTH(DW), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    regfile_gazump_mux #(.DATA_WIDTH(DW), .CNT_W(4)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct packed {
        logic [RDW-1:0]    data;
        logic [GZ_NRD-1:0] gz;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt;

    // ------------------------------------------------------------------
    // Reference model and stimulus helpers
    // ------------------------------------------------------------------
    function automatic exp_t model(input logic [MVW-1:0] m,
                                   input logic [RDW-1:0] rf,
                                   input logic [WDW-1:0] wd);
        exp_t             e;
        logic [GZ_MW-1:0] mk;
        logic [DW-1:0]    d;
        e = '0;
        for (int k = 0; k < GZ_NRD; k++) begin
            mk = m[k*GZ_MW +: GZ_MW];
            d  = '0;
            if (mk[GZ_NONE_BIT]) d = rf[k*DW +: DW];
            for (int i = 0; i < GZ_NWR; i++) begin
                if (mk[i]) d = d | wd[i*DW +: DW];
            end
            e.data[k*DW +: DW] = d;
            e.gz[k]            = ~mk[GZ_NONE_BIT];
        end
        return e;
    endfunction

    function automatic logic [RDW-1:0] rand_rf();
        logic [RDW-1:0] v;
        for (int k = 0; k < GZ_NRD; k++) v[k*DW +: DW] = $urandom();
        return v;
    endfunction

    function automatic logic [WDW-1:0] rand_wd();
        logic [WDW-1:0] v;
        for (int i = 0; i < GZ_NWR; i++) v[i*DW +: DW] = $urandom();
        return v;
    endfunction

    function automatic logic [MVW-1:0] rand_onehot();
        logic [MVW-1:0]   v;
        logic [GZ_MW-1:0] mk;
        for (int k = 0; k < GZ_NRD; k++) begin
            mk = '0;
            mk[$urandom_range(0, GZ_MW-1)] = 1'b1;
            v[k*GZ_MW +: GZ_MW] = mk;
        end
        return v;
    endfunction

    function automatic logic [MVW-1:0] all_none();
        return {GZ_NRD{11'h400}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [MVW-1:0] m,
                           input logic [RDW-1:0] rf,
                           input logic [WDW-1:0] wd);
        ifa.match    = m;
        ifa.rf_data  = rf;
        ifa.wdata    = wd;
        ifa.in_valid = 1'b1;
        sb.push_back(model(m, rf, wd));
    endtask

    // Offering a beat while in_ready is low is a protocol error by the bench.
    always @(negedge clk) begin
        if (rst === 1'b0 && ifa.in_valid === 1'b1 && ifa.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL protocol: in_valid offered while in_ready=%b", ifa.in_ready);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst           = 1'b1;
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        ifa.match     = '0;
        ifa.rf_data   = '0;
        ifa.wdata     = '0;
        ifb.in_valid  = 1'b0;
        ifb.out_ready = 1'b1;
        ifb.match     = '0;
        ifb.rf_data   = '0;
        ifb.wdata     = '0;
        step();
        step();
        rst = 1'b0;
        sb.delete();
        exp_cnt = '0;

        checks++;
        if (ifa.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", ifa.out_valid);
        end
        checks++;
        if (ifa.out_data !== '0) begin
            errors++; $display("FAIL reset_out_data: got %h expected 0", ifa.out_data);
        end
        checks++;
        if (ifa.out_gz !== '0) begin
            errors++; $display("FAIL reset_out_gz: got %h expected 0", ifa.out_gz);
        end
        checks++;
        if (ifa.err_onehot !== 1'b0) begin
            errors++; $display("FAIL reset_err_onehot: got %b expected 0", ifa.err_onehot);
        end
        checks++;
        if (ifa.gz_count !== 16'd0) begin
            errors++; $display("FAIL reset_gz_count: got %0d expected 0", ifa.gz_count);
        end
        checks++;
        if (ifa.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", ifa.in_ready);
        end
        checks++;
        if (ifb.gz_count !== 4'd0) begin
            errors++; $display("FAIL reset_sat_gz_count: got %0d expected 0", ifb.gz_count);
        end
    endtask

    task automatic test_no_gazump();
        logic [RDW-1:0] rf;
        exp_t           e;
        for (int k = 0; k < GZ_NRD; k++) rf[k*DW +: DW] = DW'(k + 1);
        ifa.out_ready = 1'b1;
        drive_a(all_none(), rf, rand_wd());
        step();
        ifa.in_valid = 1'b0;
        e = sb.pop_front();
        exp_cnt = exp_cnt + 16'($countones(e.gz));

        checks++;
        if (ifa.out_valid !== 1'b1) begin
            errors++; $display("FAIL nogz_out_valid: got %b expected 1", ifa.out_valid);
        end
        checks++;
        if (ifa.out_data !== rf) begin
            errors++; $display("FAIL nogz_out_data: got %h expected %h", ifa.out_data, rf);
        end
        checks++;
        if (ifa.out_gz !== 9'h000) begin
            errors++; $display("FAIL nogz_out_gz: got %h expected 000", ifa.out_gz);
        end
        checks++;
        if (ifa.gz_count !== 16'd0) begin
            errors++; $display("FAIL nogz_gz_count: got %0d expected 0", ifa.gz_count);
        end

        // Drained with nothing behind it: valid drops, data stays.
        step();
        checks++;
        if (ifa.out_valid !== 1'b0) begin
            errors++; $display("FAIL nogz_drain_valid: got %b expected 0", ifa.out_valid);
        end
        checks++;
        if (ifa.out_data !== e.data) begin
            errors++; $display("FAIL nogz_drain_data_kept: got %h expected %h", ifa.out_data, e.data);
        end
    endtask

    task automatic test_gazump();
        logic [MVW-1:0] m;
        logic [WDW-1:0] wd;
        exp_t           e;
        m  = all_none();
        m[3*GZ_MW +: GZ_MW] = 11'h004;
        wd = rand_wd();
        wd[2*DW +: DW] = 32'hDEAD_BEEF;
        drive_a(m, rand_rf(), wd);
        step();
        ifa.in_valid = 1'b0;
        e = sb.pop_front();
        exp_cnt = exp_cnt + 16'($countones(e.gz));

        checks++;
        if (ifa.out_data[3*DW +: DW] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL gz_port3: got %h expected deadbeef", ifa.out_data[3*DW +: DW]);
        end
        checks++;
        if (ifa.out_data !== e.data) begin
            errors++; $display("FAIL gz_out_data: got %h expected %h", ifa.out_data, e.data);
        end
        checks++;
        if (ifa.out_gz !== 9'h008) begin
            errors++; $display("FAIL gz_out_gz: got %h expected 008", ifa.out_gz);
        end
        checks++;
        if (ifa.gz_count !== 16'd1) begin
            errors++; $display("FAIL gz_count: got %0d expected 1", ifa.gz_count);
        end
        step();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        ifa.out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            drive_a(rand_onehot(), rand_rf(), rand_wd());
            #1;
            checks++;
            if (ifa.in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", b, ifa.in_ready);
            end
            step();
            e = sb.pop_front();
            exp_cnt = exp_cnt + 16'($countones(e.gz));
            checks++;
            if (ifa.out_valid !== 1'b1 || ifa.out_data !== e.data || ifa.out_gz !== e.gz) begin
                errors++;
                $display("FAIL b2b_bundle[%0d]: got v=%b gz=%h d=%h expected v=1 gz=%h d=%h",
                         b, ifa.out_valid, ifa.out_gz, ifa.out_data, e.gz, e.data);
            end
            checks++;
            if (ifa.gz_count !== exp_cnt) begin
                errors++; $display("FAIL b2b_gz_count[%0d]: got %0d expected %0d", b, ifa.gz_count, exp_cnt);
            end
        end
        ifa.in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        exp_t e;
        exp_t e2;
        ifa.out_ready = 1'b0;
        drive_a(rand_onehot(), rand_rf(), rand_wd());
        step();
        ifa.in_valid = 1'b0;
        e = sb.pop_front();
        exp_cnt = exp_cnt + 16'($countones(e.gz));
        checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_data !== e.data) begin
            errors++; $display("FAIL bp_first: got v=%b d=%h expected v=1 d=%h", ifa.out_valid, ifa.out_data, e.data);
        end

        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (ifa.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, ifa.in_ready);
            end
            checks++;
            if (ifa.out_valid !== 1'b1 || ifa.out_data !== e.data || ifa.out_gz !== e.gz
                || ifa.gz_count !== exp_cnt) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b gz=%h cnt=%0d expected v=1 gz=%h cnt=%0d",
                         c, ifa.out_valid, ifa.out_gz, ifa.gz_count, e.gz, exp_cnt);
            end
        end

        // Release and offer a new beat in the same cycle.
        drive_a(rand_onehot(), rand_rf(), rand_wd());
        ifa.out_ready = 1'b1;
        #1;
        checks++;
        if (ifa.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_in_ready: got %b expected 1", ifa.in_ready);
        end
        step();
        ifa.in_valid = 1'b0;
        e2 = sb.pop_front();
        exp_cnt = exp_cnt + 16'($countones(e2.gz));
        checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_data !== e2.data || ifa.out_gz !== e2.gz) begin
            errors++; $display("FAIL bp_replace: got v=%b d=%h expected v=1 d=%h", ifa.out_valid, ifa.out_data, e2.data);
        end
        checks++;
        if (ifa.gz_count !== exp_cnt) begin
            errors++; $display("FAIL bp_gz_count: got %0d expected %0d", ifa.gz_count, exp_cnt);
        end
        step();
    endtask

    task automatic test_multi_hot();
        logic [MVW-1:0] m;
        exp_t           e;
        ifa.out_ready = 1'b1;
        m = all_none();
        m[0 +: GZ_MW] = 11'h003;
        drive_a(m, rand_rf(), rand_wd());
        step();
        ifa.in_valid = 1'b0;
        e = sb.pop_front();
        exp_cnt = exp_cnt + 16'($countones(e.gz));
        checks++;
        if (ifa.err_onehot !== 1'b1) begin
            errors++; $display("FAIL mh_err_set: got %b expected 1", ifa.err_onehot);
        end
        checks++;
        if (ifa.out_data !== e.data || ifa.out_gz !== 9'h001) begin
            errors++; $display("FAIL mh_or_data: got gz=%h d=%h expected gz=001 d=%h", ifa.out_gz, ifa.out_data, e.data);
        end

        // Clean traffic and idle cycles do not clear the flag.
        drive_a(all_none(), rand_rf(), rand_wd());
        step();
        ifa.in_valid = 1'b0;
        e = sb.pop_front();
        exp_cnt = exp_cnt + 16'($countones(e.gz));
        step();
        step();
        checks++;
        if (ifa.err_onehot !== 1'b1) begin
            errors++; $display("FAIL mh_err_sticky: got %b expected 1", ifa.err_onehot);
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        exp_cnt = '0;
        checks++;
        if (ifa.err_onehot !== 1'b0) begin
            errors++; $display("FAIL mh_err_cleared: got %b expected 0", ifa.err_onehot);
        end

        // All-zero vector on port 5.
        m = all_none();
        m[5*GZ_MW +: GZ_MW] = 11'h000;
        drive_a(m, rand_rf(), rand_wd());
        step();
        ifa.in_valid = 1'b0;
        e = sb.pop_front();
        exp_cnt = exp_cnt + 16'($countones(e.gz));
        checks++;
        if (ifa.err_onehot !== 1'b1) begin
            errors++; $display("FAIL zero_err_set: got %b expected 1", ifa.err_onehot);
        end
        checks++;
        if (ifa.out_data[5*DW +: DW] !== 32'h0 || ifa.out_gz !== 9'h020) begin
            errors++; $display("FAIL zero_port5: got gz=%h d5=%h expected gz=020 d5=0", ifa.out_gz, ifa.out_data[5*DW +: DW]);
        end
        checks++;
        if (ifa.gz_count !== exp_cnt) begin
            errors++; $display("FAIL zero_gz_count: got %0d expected %0d", ifa.gz_count, exp_cnt);
        end
        step();
    endtask

    task automatic test_saturation();
        logic [3:0] exp_sat [4];
        exp_sat[0] = 4'd9;
        exp_sat[1] = 4'd15;
        exp_sat[2] = 4'd15;
        exp_sat[3] = 4'd15;
        ifb.out_ready = 1'b1;
        ifb.match     = {GZ_NRD{11'h001}};
        ifb.rf_data   = rand_rf();
        ifb.wdata     = rand_wd();
        ifb.in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) ifb.in_valid = 1'b0;
            step();
            checks++;
            if (ifb.gz_count !== exp_sat[c]) begin
                errors++; $display("FAIL sat_count[%0d]: got %0d expected %0d", c, ifb.gz_count, exp_sat[c]);
            end
        end
        checks++;
        if (ifb.out_gz !== 9'h1FF) begin
            errors++; $display("FAIL sat_out_gz: got %h expected 1ff", ifb.out_gz);
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [MVW-1:0] m;
        exp_t           e;
        ifa.out_ready = 1'b0;
        m = all_none();
        m[2*GZ_MW +: GZ_MW] = 11'h003;
        m[4*GZ_MW +: GZ_MW] = 11'h010;
        drive_a(m, rand_rf(), rand_wd());
        step();
        ifa.in_valid = 1'b0;
        e = sb.pop_front();
        exp_cnt = exp_cnt + 16'($countones(e.gz));
        step();
        checks++;
        if (ifa.out_valid !== 1'b1 || ifa.err_onehot !== 1'b1 || ifa.gz_count !== exp_cnt) begin
            errors++;
            $display("FAIL rmh_held: got v=%b err=%b cnt=%0d expected v=1 err=1 cnt=%0d",
                     ifa.out_valid, ifa.err_onehot, ifa.gz_count, exp_cnt);
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        exp_cnt = '0;
        checks++;
        if (ifa.out_valid !== 1'b0) begin
            errors++; $display("FAIL rmh_out_valid: got %b expected 0", ifa.out_valid);
        end
        checks++;
        if (ifa.gz_count !== 16'd0 || ifa.err_onehot !== 1'b0) begin
            errors++; $display("FAIL rmh_status: got cnt=%0d err=%b expected cnt=0 err=0", ifa.gz_count, ifa.err_onehot);
        end
        checks++;
        if (ifa.out_data !== '0 || ifa.out_gz !== '0) begin
            errors++; $display("FAIL rmh_data: got gz=%h d=%h expected 0", ifa.out_gz, ifa.out_data);
        end
        checks++;
        if (ifb.gz_count !== 4'd0) begin
            errors++; $display("FAIL rmh_sat_count: got %0d expected 0", ifb.gz_count);
        end
        ifa.out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_no_gazump();
        test_gazump();
        test_back_to_back();
        test_backpressure();
        test_multi_hot();
        test_saturation();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_gazump_mux
